// File: rtl/serial_sub_if.sv
// Start/busy/done handshake and operand/result bus for the digit-serial subtractor.
interface serial_sub_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;

  modport master (output start, a, b, bin, input busy, done, d, bout, zero);
  modport slave  (input start, a, b, bin, output busy, done, d, bout, zero);
endinterface

// File: rtl/serial_sub.sv
// Digit-serial ripple-borrow subtractor: D = A - B - bin, DIGIT bits per clock, LSB first.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic     clk,
    input logic     rst,
    serial_sub_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa, opb, res, res_nxt, d_q;
    logic             brw, bout_q, zero_q, done_q;
    logic [DIGIT:0]   bc;
    logic [DIGIT-1:0] dif;
    logic             last;

    assign last = (cnt == CW'(STEPS - 1));

    // One DIGIT-wide ripple chain, seeded by the borrow carried from the previous cycle
    assign bc[0] = brw;
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign dif[i]   = opa[i] ^ opb[i] ^ bc[i];
        assign bc[i+1]  = (~opa[i] & (opb[i] | bc[i])) | (opb[i] & bc[i]);
    end

    // New slice enters at the top; after STEPS shifts the LSB slice has reached bit 0
    assign res_nxt = (res >> DIGIT) | (WIDTH'(dif) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (bus.start) state_nxt = RUN;
        end else begin
            if (last) state_nxt = IDLE;
        end
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = done_q;
        bus.d    = d_q;
        bus.bout = bout_q;
        bus.zero = zero_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            brw    <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    opa <= bus.a;
                    opb <= bus.b;
                    brw <= bus.bin;
                    cnt <= '0;
                end
            end else begin
                opa <= opa >> DIGIT;
                opb <= opb >> DIGIT;
                brw <= bc[DIGIT];
                res <= res_nxt;
                cnt <= cnt + CW'(1);
                // Visible outputs move only on completion so partial sums never leak
                if (last) begin
                    d_q    <= res_nxt;
                    bout_q <= bc[DIGIT];
                    zero_q <= (res_nxt == '0);
                    done_q <= 1'b1;
                end
            end
        end
    end
endmodule
